// File: rtl/gen_debug_data_scan_mux.sv
// gen_debug_data_scan_mux
// Slices NUM_OF_IN_DATA_BUSES debug buses into OUT_DATA_BUS_WIDTH words. The
// last word of each bus is zero-padded at the MSBs.
// Live mode:  two-stage registered word select (one-hot, then AND-OR).
// Scan mode:  atomic snapshot of every bus, streamed out over valid/ready.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_data_bus       concatenated input buses, bus b at [b*IN +: IN]
//   in_data_sel       live-mode word index
//   mode              0 = live, 1 = scan
//   scan_start        single-cycle scan request
//   scan_all          1 = scan every word, 0 = scan bus scan_bus_sel only
//   scan_bus_sel      bus to scan when scan_all = 0
//   out_ready         downstream ready (scan mode)
//   out_data_bus      output word
//   out_valid         scan word valid
//   out_last          current scan word is the final one
//   out_word_idx      index of the word on out_data_bus
//   scan_busy         scan in progress
//   scan_done         one-cycle pulse after the last handshake
//   scan_err          one-cycle pulse on an illegal scan request
module gen_debug_data_scan_mux #(
  parameter int unsigned IN_DATA_BUS_WIDTH    = 100,
  parameter int unsigned NUM_OF_IN_DATA_BUSES = 3,
  parameter int unsigned OUT_DATA_BUS_WIDTH   = 32,
  localparam int unsigned WPB   = (IN_DATA_BUS_WIDTH + OUT_DATA_BUS_WIDTH - 1) / OUT_DATA_BUS_WIDTH,
  localparam int unsigned OPTS  = NUM_OF_IN_DATA_BUSES * WPB,
  localparam int unsigned SELW  = ($clog2(OPTS) > 1) ? $clog2(OPTS) : 1,
  localparam int unsigned BSELW = ($clog2(NUM_OF_IN_DATA_BUSES) > 1) ? $clog2(NUM_OF_IN_DATA_BUSES) : 1
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [NUM_OF_IN_DATA_BUSES*IN_DATA_BUS_WIDTH-1:0] in_data_bus,
  input  logic [SELW-1:0]                                   in_data_sel,
  input  logic                                              mode,
  input  logic                                              scan_start,
  input  logic                                              scan_all,
  input  logic [BSELW-1:0]                                  scan_bus_sel,
  input  logic                                              out_ready,
  output logic [OUT_DATA_BUS_WIDTH-1:0]                     out_data_bus,
  output logic                                              out_valid,
  output logic                                              out_last,
  output logic [SELW-1:0]                                   out_word_idx,
  output logic                                              scan_busy,
  output logic                                              scan_done,
  output logic                                              scan_err
);

  localparam int unsigned IN      = IN_DATA_BUS_WIDTH;
  localparam int unsigned OUT     = OUT_DATA_BUS_WIDTH;
  localparam int unsigned NBUS    = NUM_OF_IN_DATA_BUSES;
  localparam int unsigned BUSW    = NBUS * IN;
  localparam int unsigned WORDS_W = WPB * OUT;
  localparam int unsigned PADW    = OPTS * OUT;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  // Re-pack buses so every bus occupies exactly WPB words (zero-padded MSBs).
  function automatic logic [PADW-1:0] pad(input logic [BUSW-1:0] v);
    logic [PADW-1:0] p;
    p = '0;
    for (int unsigned b = 0; b < NBUS; b++) begin
      p[b*WORDS_W +: WORDS_W] = WORDS_W'(v[b*IN +: IN]);
    end
    return p;
  endfunction

  // Word select by binary index; out-of-range gives zero.
  function automatic logic [OUT-1:0] pick(input logic [PADW-1:0] v, input logic [SELW-1:0] k);
    logic [OUT-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < OPTS; i++) begin
      if (k == SELW'(i)) w = v[i*OUT +: OUT];
    end
    return w;
  endfunction

  // Word select by one-hot mask (AND-OR, no priority).
  function automatic logic [OUT-1:0] andor(input logic [PADW-1:0] v, input logic [OPTS-1:0] oh);
    logic [OUT-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < OPTS; i++) begin
      w = w | (v[i*OUT +: OUT] & {OUT{oh[i]}});
    end
    return w;
  endfunction

  state_t            state_q, state_d;
  logic [BUSW-1:0]   snap_q, snap_d;
  logic [SELW-1:0]   first_q, first_d;
  logic [SELW-1:0]   last_q, last_d;
  logic [OPTS-1:0]   onehot_q, onehot_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [OUT-1:0]    data_d;
  logic [SELW-1:0]   idx_d;
  logic              valid_d, last_flag_d, busy_d, done_d, err_d;

  logic [PADW-1:0]   live_pad;
  logic [PADW-1:0]   snap_pad;
  logic [SELW-1:0]   next_idx;
  logic [SELW-1:0]   bus_base;

  assign live_pad = pad(in_data_bus);
  assign snap_pad = pad(snap_q);
  assign next_idx = out_word_idx + SELW'(1);
  assign bus_base = SELW'(scan_bus_sel) * SELW'(WPB);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      first_q      <= '0;
      last_q       <= '0;
      onehot_q     <= '0;
      sel_q        <= '0;
      out_data_bus <= '0;
      out_word_idx <= '0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      scan_busy    <= 1'b0;
      scan_done    <= 1'b0;
      scan_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      first_q      <= first_d;
      last_q       <= last_d;
      onehot_q     <= onehot_d;
      sel_q        <= sel_d;
      out_data_bus <= data_d;
      out_word_idx <= idx_d;
      out_valid    <= valid_d;
      out_last     <= last_flag_d;
      scan_busy    <= busy_d;
      scan_done    <= done_d;
      scan_err     <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    first_d     = first_q;
    last_d      = last_q;
    onehot_d    = onehot_q;
    sel_d       = sel_q;
    data_d      = out_data_bus;
    idx_d       = out_word_idx;
    valid_d     = out_valid;
    last_flag_d = out_last;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mode) begin
          // Live pipeline frozen; only a scan request is acted on.
          if (scan_start) begin
            if (!scan_all && (32'(scan_bus_sel) >= NBUS)) begin
              err_d = 1'b1;
            end else begin
              state_d = LOAD;
              snap_d  = in_data_bus;
              first_d = scan_all ? '0 : bus_base;
              last_d  = scan_all ? SELW'(OPTS - 1) : bus_base + SELW'(WPB - 1);
            end
          end
        end else begin
          // Stage 1 registers the one-hot; stage 2 applies it to the live buses.
          onehot_d = (32'(in_data_sel) < OPTS) ? (OPTS'(1) << in_data_sel) : '0;
          sel_d    = in_data_sel;
          data_d   = andor(live_pad, onehot_q);
          idx_d    = sel_q;
        end
      end

      LOAD: begin
        if (!mode) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          last_flag_d = 1'b0;
        end else begin
          state_d     = SEND;
          data_d      = pick(snap_pad, first_q);
          idx_d       = first_q;
          valid_d     = 1'b1;
          last_flag_d = (first_q == last_q);
        end
      end

      SEND: begin
        if (!mode) begin
          state_d     = IDLE;
          valid_d     = 1'b0;
          last_flag_d = 1'b0;
        end else if (out_valid && out_ready) begin
          if (out_last) begin
            state_d     = IDLE;
            valid_d     = 1'b0;
            last_flag_d = 1'b0;
            done_d      = 1'b1;
          end else begin
            data_d      = pick(snap_pad, next_idx);
            idx_d       = next_idx;
            last_flag_d = (next_idx == last_q);
          end
        end
      end

      default: begin
        state_d     = IDLE;
        valid_d     = 1'b0;
        last_flag_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_gen_debug_data_scan_mux.sv
// Self-checking bench for gen_debug_data_scan_mux (default parameters).
module tb_gen_debug_data_scan_mux;

  localparam int IN    = 100;
  localparam int NBUS  = 3;
  localparam int OUT   = 32;
  localparam int WPB   = 4;
  localparam int OPTS  = 12;
  localparam int SELW  = 4;
  localparam int BSELW = 2;
  localparam int BUSW  = NBUS * IN;

  logic              clk;
  logic              rst_n;
  logic [BUSW-1:0]   in_data_bus;
  logic [SELW-1:0]   in_data_sel;
  logic              mode;
  logic              scan_start;
  logic              scan_all;
  logic [BSELW-1:0]  scan_bus_sel;
  logic              out_ready;
  logic [OUT-1:0]    out_data_bus;
  logic              out_valid;
  logic              out_last;
  logic [SELW-1:0]   out_word_idx;
  logic              scan_busy;
  logic              scan_done;
  logic              scan_err;

  int checks   = 0;
  int failures = 0;

  logic [BUSW-1:0] snap_m;
  int              rq[$];

  gen_debug_data_scan_mux #(
    .IN_DATA_BUS_WIDTH   (IN),
    .NUM_OF_IN_DATA_BUSES(NBUS),
    .OUT_DATA_BUS_WIDTH  (OUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data_bus (in_data_bus),
    .in_data_sel (in_data_sel),
    .mode        (mode),
    .scan_start  (scan_start),
    .scan_all    (scan_all),
    .scan_bus_sel(scan_bus_sel),
    .out_ready   (out_ready),
    .out_data_bus(out_data_bus),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_word_idx(out_word_idx),
    .scan_busy   (scan_busy),
    .scan_done   (scan_done),
    .scan_err    (scan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  // Reference: word k is bit-by-bit bus b = k/WPB, offset (k%WPB)*OUT; past IN is zero.
  function automatic logic [OUT-1:0] mword(input logic [BUSW-1:0] v, input int k);
    logic [OUT-1:0] w;
    int b, j, p;
    w = '0;
    if (k < 0 || k >= OPTS) return w;
    b = k / WPB;
    j = k % WPB;
    for (int t = 0; t < OUT; t++) begin
      p = j * OUT + t;
      if (p < IN) w[t] = v[b*IN + p];
    end
    return w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_bus();
    for (int i = 0; i < BUSW; i++) in_data_bus[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"},  64'(out_last),  64'd0);
    chk({tag, "_busy"},  64'(scan_busy), 64'd0);
  endtask

  // Issue a scan request; optionally invert the live buses right after capture.
  task automatic start_scan(input logic all, input int bsel, input bit invert);
    mode         = 1'b1;
    scan_all     = all;
    scan_bus_sel = BSELW'(bsel);
    scan_start   = 1'b1;
    out_ready    = 1'b0;
    snap_m       = in_data_bus;
    tick();
    scan_start = 1'b0;
    if (invert) in_data_bus = ~in_data_bus;
    chk("start_busy",   64'(scan_busy), 64'd1);
    chk("start_valid0", 64'(out_valid), 64'd0);
    tick();
    chk("start_valid1", 64'(out_valid), 64'd1);
  endtask

  // Consume a scan. rmode 0: ready always; 1: random ready; 2: pattern from rq then 1.
  task automatic collect(input int first, input int last, input int rmode, input bit poke,
                         input bit scramble, output int hs);
    int  k;
    int  guard;
    bit  r;
    k     = first;
    guard = 0;
    hs    = 0;
    while (k <= last && guard < 200) begin
      guard++;
      chk("scan_valid", 64'(out_valid),    64'd1);
      chk("scan_idx",   64'(out_word_idx), 64'(k));
      chk("scan_data",  64'(out_data_bus), 64'(mword(snap_m, k)));
      chk("scan_last",  64'(out_last),     64'(k == last));
      chk("scan_err0",  64'(scan_err),     64'd0);
      chk("scan_done0", 64'(scan_done),    64'd0);
      case (rmode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (rq.size() > 0) ? 1'(rq.pop_front()) : 1'b1;
      endcase
      out_ready  = r;
      scan_start = (poke && guard == 2);
      if (poke && guard == 2) scan_all = 1'b1;
      if (scramble) rand_bus();
      tick();
      scan_start = 1'b0;
      if (r) begin
        k++;
        hs++;
      end
    end
    chk("scan_complete", 64'(k), 64'(last + 1));
    chk("scan_done1",    64'(scan_done), 64'd1);
    chk("scan_end_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    tick();
    chk("scan_done_pulse", 64'(scan_done), 64'd0);
    chk_idle_outputs("post_scan");
  endtask

  initial begin
    int             hs;
    int             s;
    logic [OUT-1:0] held;

    rst_n        = 1'b0;
    in_data_bus  = '0;
    in_data_sel  = '0;
    mode         = 1'b0;
    scan_start   = 1'b0;
    scan_all     = 1'b0;
    scan_bus_sel = '0;
    out_ready    = 1'b0;
    #12;
    chk("rst_data", 64'(out_data_bus), 64'd0);
    chk("rst_idx",  64'(out_word_idx), 64'd0);
    chk("rst_done", 64'(scan_done),    64'd0);
    chk("rst_err",  64'(scan_err),     64'd0);
    chk_idle_outputs("rst");
    rst_n = 1'b1;
    tick();

    // Live: padded last word of bus 0.
    rand_bus();
    in_data_bus[96 +: 4] = 4'hF;
    in_data_sel = 4'd3;
    tick();
    tick();
    chk("live_pad_const", 64'(out_data_bus), 64'h0000000F);
    chk("live_pad_model", 64'(out_data_bus), 64'(mword(in_data_bus, 3)));
    chk("live_pad_idx",   64'(out_word_idx), 64'd3);
    chk("live_valid",     64'(out_valid),    64'd0);

    // Live: out-of-range index selects zero.
    in_data_sel = 4'd13;
    tick();
    tick();
    chk("live_oor_data", 64'(out_data_bus), 64'd0);
    chk("live_oor_idx",  64'(out_word_idx), 64'd13);

    // Live: random buses and indices, including out-of-range ones.
    for (int n = 0; n < 10; n++) begin
      rand_bus();
      in_data_sel = SELW'($urandom_range(0, 15));
      tick();
      tick();
      chk("live_rand_data", 64'(out_data_bus), 64'(mword(in_data_bus, int'(in_data_sel))));
      chk("live_rand_idx",  64'(out_word_idx), 64'(in_data_sel));
      chk("live_rand_busy", 64'(scan_busy),    64'd0);
    end

    // Live pipeline throughput: a new index each cycle, result two edges later.
    rand_bus();
    in_data_sel = 4'd0;
    tick();
    in_data_sel = 4'd5;
    tick();
    chk("live_pipe0", 64'(out_data_bus), 64'(mword(in_data_bus, 0)));
    in_data_sel = 4'd10;
    tick();
    chk("live_pipe1", 64'(out_data_bus), 64'(mword(in_data_bus, 5)));
    tick();
    chk("live_pipe2", 64'(out_data_bus), 64'(mword(in_data_bus, 10)));

    // mode=1 without a scan freezes the output.
    held = out_data_bus;
    mode = 1'b1;
    in_data_sel = 4'd1;
    rand_bus();
    tick();
    tick();
    tick();
    chk("frozen_data", 64'(out_data_bus), 64'(held));
    chk_idle_outputs("frozen");

    // Scan bus 1, always ready.
    rand_bus();
    start_scan(1'b0, 1, 1'b0);
    collect(4, 7, 0, 1'b0, 1'b1, hs);
    chk("bus1_handshakes", 64'(hs), 64'd4);

    // Scan bus 2 with backpressure on word 9.
    rand_bus();
    rq = '{1, 0, 0, 1};
    start_scan(1'b0, 2, 1'b0);
    collect(8, 11, 2, 1'b0, 1'b0, hs);
    chk("bus2_handshakes", 64'(hs), 64'd4);

    // Snapshot isolation: all words, buses inverted right after capture.
    rand_bus();
    start_scan(1'b1, 0, 1'b1);
    collect(0, 11, 0, 1'b0, 1'b0, hs);
    chk("all_handshakes", 64'(hs), 64'd12);

    // Full scan with random ready and changing buses.
    rand_bus();
    start_scan(1'b1, 0, 1'b0);
    collect(0, 11, 1, 1'b0, 1'b1, hs);

    // Illegal bus index.
    mode         = 1'b1;
    scan_all     = 1'b0;
    scan_bus_sel = 2'd3;
    scan_start   = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("err_pulse", 64'(scan_err),  64'd1);
    chk("err_busy",  64'(scan_busy), 64'd0);
    chk("err_valid", 64'(out_valid), 64'd0);
    tick();
    chk("err_clear", 64'(scan_err),  64'd0);
    chk("err_busy2", 64'(scan_busy), 64'd0);

    // A second scan_start during a scan is ignored.
    rand_bus();
    start_scan(1'b0, 0, 1'b0);
    collect(0, 3, 0, 1'b1, 1'b0, hs);
    chk("poke_handshakes", 64'(hs), 64'd4);

    // Abort by dropping mode at word 5.
    rand_bus();
    start_scan(1'b0, 1, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("abort_idx5", 64'(out_word_idx), 64'd5);
    out_ready = 1'b0;
    mode      = 1'b0;
    s         = $urandom_range(0, OPTS - 1);
    in_data_sel = SELW'(s);
    tick();
    chk("abort_done", 64'(scan_done), 64'd0);
    chk_idle_outputs("abort");
    tick();
    chk("abort_done2", 64'(scan_done), 64'd0);
    tick();
    chk("abort_live_data", 64'(out_data_bus), 64'(mword(in_data_bus, s)));
    chk("abort_live_idx",  64'(out_word_idx), 64'(s));

    // Asynchronous reset in the middle of a scan.
    rand_bus();
    start_scan(1'b1, 0, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_data", 64'(out_data_bus), 64'd0);
    chk("mrst_idx",  64'(out_word_idx), 64'd0);
    chk_idle_outputs("mrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_done", 64'(scan_done), 64'd0);
    chk("mrst_err",  64'(scan_err),  64'd0);
    chk_idle_outputs("mrst_after");

    // FSM is back in IDLE and accepts a fresh scan.
    rand_bus();
    start_scan(1'b0, 2, 1'b0);
    collect(8, 11, 0, 1'b0, 1'b0, hs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
